// File: rtl/cgra_dma_pkg.sv
// cgra_dma_pkg: DMA command codes shared with the funct decoder and engine state encoding
package cgra_dma_pkg;
    typedef enum logic [1:0] {
        DMA_NOP = 2'b00,
        DMA_STC = 2'b01,
        DMA_LFC = 2'b10,
        DMA_SCA = 2'b11
    } dma_cmd_e;
    typedef enum logic [3:0] {
        IDLE,
        RD_MEM,
        WR_BUF,
        RD_BUF,
        WAIT_BUF,
        WR_MEM,
        START,
        WAIT_CGRA,
        DONE
    } dma_state_e;
endpackage

// File: rtl/cgra_dma_engine_xfer_counter.sv
// dma_xfer_counter: memory/buffer address walkers and remaining-word counter
module dma_xfer_counter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BUF_AW = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] mem_base,
    input  logic [BUF_AW-1:0] buf_base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BUF_AW-1:0] buf_addr,
    output logic              last
);
    import cgra_dma_pkg::*;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
    logic [LEN_W-1:0] cnt;
    assign last = cnt == LEN_W'(1);
    // load bases and length on accept; advance one word per completed transfer, wrapping naturally
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            mem_addr <= '0;
            buf_addr <= '0;
            cnt      <= '0;
        end else if (load) begin
            mem_addr <= mem_base;
            buf_addr <= buf_base;
            cnt      <= len;
        end else if (step) begin
            mem_addr <= mem_addr + STRIDE;
            buf_addr <= buf_addr + BUF_AW'(1);
            cnt      <= cnt - LEN_W'(1);
        end
endmodule

// File: rtl/cgra_dma_engine.sv
// cgra_dma_engine: moves word blocks between data memory and the CGRA buffer, or launches the CGRA
module cgra_dma_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BUF_AW = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    input  logic [1:0]        dma_ctrl_i,
    input  logic [ADDR_W-1:0] mem_base_i,
    input  logic [BUF_AW-1:0] buf_base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              buf_we_o,
    output logic [BUF_AW-1:0] buf_addr_o,
    output logic [DATA_W-1:0] buf_wdata_o,
    input  logic [DATA_W-1:0] buf_rdata_i,
    output logic              cgra_start_o,
    input  logic              cgra_done_i
);
    import cgra_dma_pkg::*;
    dma_state_e        state, nxt;
    logic              accept, load, step, last;
    logic [DATA_W-1:0] data;
    assign accept       = state == IDLE && cmd_valid_i && dma_ctrl_i != DMA_NOP;
    assign busy_o       = state != IDLE;
    assign stall_o      = busy_o | accept;
    assign done_o       = state == DONE;
    assign mem_req_o    = state == RD_MEM || state == WR_MEM;
    assign mem_we_o     = state == WR_MEM;
    assign buf_we_o     = state == WR_BUF;
    assign cgra_start_o = state == START;
    assign mem_wdata_o  = data;
    assign buf_wdata_o  = data;
    dma_xfer_counter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_AW(BUF_AW), .LEN_W(LEN_W)) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (load),
        .step    (step),
        .mem_base(mem_base_i),
        .buf_base(buf_base_i),
        .len     (len_i),
        .mem_addr(mem_addr_o),
        .buf_addr(buf_addr_o),
        .last    (last)
    );
    // state register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= nxt;
    // data word in flight: memory read at ack, or buffer read one cycle after its address
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) data <= '0;
        else if (state == RD_MEM && mem_ack_i) data <= mem_rdata_i;
        else if (state == WAIT_BUF) data <= buf_rdata_i;
    // next state, counter load on accept and counter step on each finished word
    always_comb begin
        nxt  = state;
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE: if (accept) begin
                load = 1'b1;
                if (dma_ctrl_i == DMA_SCA) nxt = START;
                else if (len_i == '0) nxt = DONE;
                else if (dma_ctrl_i == DMA_STC) nxt = RD_MEM;
                else nxt = RD_BUF;
            end
            RD_MEM:    if (mem_ack_i) nxt = WR_BUF;
            WR_BUF: begin
                step = 1'b1;
                nxt  = last ? DONE : RD_MEM;
            end
            RD_BUF:    nxt = WAIT_BUF;
            WAIT_BUF:  nxt = WR_MEM;
            WR_MEM: if (mem_ack_i) begin
                step = 1'b1;
                nxt  = last ? DONE : RD_BUF;
            end
            START:     nxt = WAIT_CGRA;
            WAIT_CGRA: if (cgra_done_i) nxt = DONE;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end
endmodule
